// File: rtl/smc_ahb_sram_ctrl.sv
// smc_ahb_sram_ctrl: AHB-Lite slave to single-port SRAM with one-entry write buffer and read forwarding
module smc_ahb_sram_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              pmu_smc_hclk,
    input  logic              pmu_smc_hrst,
    input  logic              hmain0_smc_hsel,
    input  logic [31:0]       hmain0_smc_haddr,
    input  logic [1:0]        hmain0_smc_htrans,
    input  logic              hmain0_smc_hwrite,
    input  logic [2:0]        hmain0_smc_hsize,
    input  logic [3:0]        hmain0_smc_hprot,
    input  logic [31:0]       hmain0_smc_hwdata,
    output logic [31:0]       smc_hmain0_hrdata,
    output logic              smc_hmain0_hready,
    output logic [1:0]        smc_hmain0_hresp,
    output logic              smc_sram_cen,
    output logic              smc_sram_wen,
    output logic [ADDR_W-3:0] smc_sram_addr,
    output logic [3:0]        smc_sram_be,
    output logic [31:0]       smc_sram_wdata,
    input  logic [31:0]       sram_smc_rdata
);
    localparam int WA = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, RD_DATA, WR_DATA, ERR1, ERR2} state_t;

    state_t        state, state_nx;
    logic [WA-1:0] a_addr, buf_addr;
    logic [3:0]    a_be, buf_be, be_c;
    logic [31:0]   buf_data, merged;
    logic          buf_valid, accept, legal, rd_acc, flush, load, hit;
    logic          unused;

    assign unused = ^{hmain0_smc_hprot, hmain0_smc_haddr[31:ADDR_W], hmain0_smc_htrans[0]};

    // Address-phase decode, SRAM port arbitration (read beats flush) and read merge
    always_comb begin
        be_c = hmain0_smc_hsize == 3'd0 ? 4'b0001 << hmain0_smc_haddr[1:0] :
               hmain0_smc_hsize == 3'd1 ? (hmain0_smc_haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        legal = hmain0_smc_hsize <= 3'd2 &&
                !(hmain0_smc_hsize == 3'd1 && hmain0_smc_haddr[0]) &&
                !(hmain0_smc_hsize == 3'd2 && |hmain0_smc_haddr[1:0]);
        smc_hmain0_hready = state != ERR1;
        smc_hmain0_hresp  = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
        accept = hmain0_smc_hsel & hmain0_smc_htrans[1] & smc_hmain0_hready & ~pmu_smc_hrst;
        rd_acc = accept & legal & ~hmain0_smc_hwrite;
        flush  = buf_valid & ~rd_acc & ~pmu_smc_hrst;
        load   = state == WR_DATA & ~pmu_smc_hrst;
        hit    = buf_valid && buf_addr == a_addr;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = (hit && buf_be[i]) ? buf_data[8*i +: 8] : sram_smc_rdata[8*i +: 8];
        smc_hmain0_hrdata = state == RD_DATA ? merged : 32'h0;
        smc_sram_cen   = rd_acc | flush;
        smc_sram_wen   = flush;
        smc_sram_addr  = rd_acc ? hmain0_smc_haddr[ADDR_W-1:2] : buf_addr;
        smc_sram_be    = flush ? buf_be : 4'b0000;
        smc_sram_wdata = buf_data;
        state_nx = accept ? (legal ? (hmain0_smc_hwrite ? WR_DATA : RD_DATA) : ERR1) :
                   state == ERR1 ? ERR2 : IDLE;
    end

    // FSM state, buffer valid bit, address-phase capture and write-buffer load
    always_ff @(posedge pmu_smc_hclk) begin
        if (pmu_smc_hrst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            buf_valid <= load | (buf_valid & ~flush);
            if (accept) begin
                a_addr <= hmain0_smc_haddr[ADDR_W-1:2];
                a_be   <= be_c;
            end
            if (load) begin
                buf_addr <= a_addr;
                buf_be   <= a_be;
                buf_data <= hmain0_smc_hwdata;
            end
        end
    end
endmodule

// File: tb/tb_smc_ahb_sram_ctrl.sv
// tb_smc_ahb_sram_ctrl: table-driven cycle checks plus reset corner sequences
module tb_smc_ahb_sram_ctrl;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        cen;
        logic        wen;
        logic [13:0] sa;
        logic [3:0]  be;
        logic [31:0] swd;
    } row_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        sel = 1'b0, wr = 1'b0;
    logic [1:0]  tr = ID;
    logic [2:0]  sz = 3'd0;
    logic [3:0]  prot = 4'h0;
    logic [31:0] addr = 32'h0, wd = 32'h0, rdata, srd;
    logic        rdy, cen, wen;
    logic [1:0]  resp;
    logic [13:0] sa;
    logic [3:0]  be;
    logic [31:0] swd;
    logic [31:0] mem [0:16383];
    int          total = 0, passed = 0;
    row_t        t [27];

    always #5 clk = ~clk;

    smc_ahb_sram_ctrl #(.ADDR_W(16)) dut (
        .pmu_smc_hclk(clk), .pmu_smc_hrst(rst),
        .hmain0_smc_hsel(sel), .hmain0_smc_haddr(addr), .hmain0_smc_htrans(tr),
        .hmain0_smc_hwrite(wr), .hmain0_smc_hsize(sz), .hmain0_smc_hprot(prot),
        .hmain0_smc_hwdata(wd), .smc_hmain0_hrdata(rdata), .smc_hmain0_hready(rdy),
        .smc_hmain0_hresp(resp), .smc_sram_cen(cen), .smc_sram_wen(wen),
        .smc_sram_addr(sa), .smc_sram_be(be), .smc_sram_wdata(swd),
        .sram_smc_rdata(srd)
    );

    // Behavioural SRAM: byte-enabled write, registered read data
    always @(posedge clk) begin
        if (cen && wen) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[sa][8*i +: 8] <= swd[8*i +: 8];
        end else if (cen) begin
            srd <= mem[sa];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    task automatic drive(input logic s, input logic [1:0] tt, input logic w, input logic [2:0] z,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = s; tr = tt; wr = w; sz = z; addr = a; wd = d;
        #2;
    endtask

    task automatic chk_bus(input string nm, input logic r, input logic [1:0] rs, input logic [31:0] rd,
                           input logic c);
        chk($sformatf("%s hready", nm), {31'b0, rdy}, {31'b0, r});
        chk($sformatf("%s hresp", nm), {30'b0, resp}, {30'b0, rs});
        chk($sformatf("%s hrdata", nm), rdata, rd);
        chk($sformatf("%s cen", nm), {31'b0, cen}, {31'b0, c});
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        srd = 32'h0;
        t[0]  = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[1]  = '{1'b1, NS, 1'b1, 3'd2, 32'h10, 32'h0,        1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[2]  = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h12345678, 1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[3]  = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'h0,        1'b1, 1'b1, 14'h4,  4'hF, 32'h12345678};
        t[4]  = '{1'b1, NS, 1'b0, 3'd2, 32'h10, 32'h0,        1'b1, 2'b00, 32'h0,        1'b1, 1'b0, 14'h4,  4'h0, 32'h0};
        t[5]  = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'h12345678, 1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[6]  = '{1'b1, NS, 1'b1, 3'd2, 32'h20, 32'h0,        1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[7]  = '{1'b1, NS, 1'b0, 3'd2, 32'h20, 32'hAABBCCDD, 1'b1, 2'b00, 32'h0,        1'b1, 1'b0, 14'h8,  4'h0, 32'h0};
        t[8]  = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'hAABBCCDD, 1'b1, 1'b1, 14'h8,  4'hF, 32'hAABBCCDD};
        t[9]  = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[10] = '{1'b1, NS, 1'b1, 3'd2, 32'h20, 32'h0,        1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[11] = '{1'b1, NS, 1'b1, 3'd0, 32'h23, 32'h11223344, 1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[12] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'hEE000000, 1'b1, 2'b00, 32'h0,        1'b1, 1'b1, 14'h8,  4'hF, 32'h11223344};
        t[13] = '{1'b1, NS, 1'b0, 3'd2, 32'h20, 32'h0,        1'b1, 2'b00, 32'h0,        1'b1, 1'b0, 14'h8,  4'h0, 32'h0};
        t[14] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'hEE223344, 1'b1, 1'b1, 14'h8,  4'h8, 32'hEE000000};
        t[15] = '{1'b1, NS, 1'b0, 3'd2, 32'h20, 32'h0,        1'b1, 2'b00, 32'h0,        1'b1, 1'b0, 14'h8,  4'h0, 32'h0};
        t[16] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'hEE223344, 1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[17] = '{1'b1, NS, 1'b0, 3'd1, 32'h41, 32'h0,        1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[18] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b0, 2'b01, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[19] = '{1'b1, NS, 1'b0, 3'd2, 32'h10, 32'h0,        1'b1, 2'b01, 32'h0,        1'b1, 1'b0, 14'h4,  4'h0, 32'h0};
        t[20] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'h12345678, 1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[21] = '{1'b1, NS, 1'b1, 3'd2, 32'h50, 32'h0,        1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[22] = '{1'b1, NS, 1'b1, 3'd3, 32'h60, 32'hCAFEF00D, 1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[23] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'hDEADBEEF, 1'b0, 2'b01, 32'h0,        1'b1, 1'b1, 14'h14, 4'hF, 32'hCAFEF00D};
        t[24] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b01, 32'h0,        1'b0, 1'b0, 14'h0,  4'h0, 32'h0};
        t[25] = '{1'b1, NS, 1'b0, 3'd2, 32'h50, 32'h0,        1'b1, 2'b00, 32'h0,        1'b1, 1'b0, 14'h14, 4'h0, 32'h0};
        t[26] = '{1'b0, ID, 1'b0, 3'd0, 32'h0,  32'h0,        1'b1, 2'b00, 32'hCAFEF00D, 1'b0, 1'b0, 14'h0,  4'h0, 32'h0};

        rst = 1'b1;
        drive(1'b0, ID, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b0, ID, 1'b0, 3'd0, 32'h0, 32'h0);
        chk_bus("reset", 1'b1, 2'b00, 32'h0, 1'b0);
        rst = 1'b0;

        for (int r = 0; r < 27; r++) begin
            drive(t[r].sel, t[r].tr, t[r].wr, t[r].sz, t[r].addr, t[r].wd);
            chk_bus($sformatf("row%0d", r), t[r].rdy, t[r].resp, t[r].rdata, t[r].cen);
            if (t[r].cen) begin
                chk($sformatf("row%0d wen", r), {31'b0, wen}, {31'b0, t[r].wen});
                chk($sformatf("row%0d addr", r), {18'b0, sa}, {18'b0, t[r].sa});
                chk($sformatf("row%0d be", r), {28'b0, be}, {28'b0, t[r].be});
                if (t[r].wen) chk($sformatf("row%0d wdata", r), swd, t[r].swd);
            end
        end

        drive(1'b1, NS, 1'b1, 3'd2, 32'h70, 32'h0);
        chk("rst_wr_addr cen", {31'b0, cen}, 32'h0);
        drive(1'b0, ID, 1'b0, 3'd0, 32'h0, 32'h55555555);
        rst = 1'b1;
        #0;
        chk("rst_wr_data cen", {31'b0, cen}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, ID, 1'b0, 3'd0, 32'h0, 32'h0);
            rst = 1'b0;
            #0;
            chk_bus($sformatf("post_rst%0d", k), 1'b1, 2'b00, 32'h0, 1'b0);
        end
        drive(1'b1, NS, 1'b0, 3'd2, 32'h70, 32'h0);
        chk("rd70 cen", {31'b0, cen}, 32'h1);
        chk("rd70 wen", {31'b0, wen}, 32'h0);
        drive(1'b0, ID, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("rd70 hrdata", rdata, 32'h0);
        chk("mem70 untouched", mem[14'h1C], 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
